// File: rtl/fp_add_arbiter.sv
// Round-robin front end for one shared fixed-latency fp32 adder. Requester IDs ride a
// tag pipe matched to the adder latency, so each result is steered back to its issuer.
module fp_add_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int LATENCY = 5,
  parameter int IDW     = $clog2(NUM_REQ)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           hold,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [32*NUM_REQ-1:0]          req_a,
  input  logic [32*NUM_REQ-1:0]          req_b,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic                           add_en,
  output logic [31:0]                    add_a,
  output logic [31:0]                    add_b,
  input  logic [31:0]                    add_result,
  output logic [NUM_REQ-1:0]             rsp_valid,
  output logic [31:0]                    rsp_data,
  output logic [$clog2(LATENCY+1)-1:0]   in_flight,
  output logic                           idle
);

  localparam int DATA_W = 32;
  localparam int CNT_W  = $clog2(LATENCY+1);

  logic [IDW-1:0]     ptr;
  logic               gnt_any;
  logic [IDW-1:0]     gnt_id;
  logic [LATENCY-1:0] vld_p;
  logic [IDW-1:0]     id_p [LATENCY];
  logic               retire;

  // Stage p0 (combinational): scan from ptr upward with wrap at NUM_REQ
  always_comb begin
    int             sum;
    logic [IDW-1:0] sel;
    gnt_any = 1'b0;
    gnt_id  = '0;
    sum     = 0;
    sel     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = int'(ptr) + k;
      if (sum >= NUM_REQ) sum = sum - NUM_REQ;
      sel = IDW'(sum);
      if (!gnt_any && req_valid[sel]) begin
        gnt_any = 1'b1;
        gnt_id  = sel;
      end
    end
    if (hold) gnt_any = 1'b0;
  end

  always_comb begin
    req_ready = '0;
    if (gnt_any) req_ready[gnt_id] = 1'b1;
  end

  assign add_en = gnt_any;
  assign add_a  = gnt_any ? req_a[int'(gnt_id)*DATA_W +: DATA_W] : '0;
  assign add_b  = gnt_any ? req_b[int'(gnt_id)*DATA_W +: DATA_W] : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (add_en) begin
      ptr <= (int'(gnt_id) == NUM_REQ-1) ? '0 : gnt_id + 1'b1;
    end
  end

  // Stages p0..p(LATENCY-1): tag pipe, never stalls; only the valid bits are reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p <= '0;
    end else begin
      vld_p[0] <= add_en;
      for (int k = 1; k < LATENCY; k++) vld_p[k] <= vld_p[k-1];
    end
  end

  always_ff @(posedge clk) begin
    id_p[0] <= gnt_id;
    for (int k = 1; k < LATENCY; k++) id_p[k] <= id_p[k-1];
  end

  // Retire: steer the unregistered adder output to the tagged requester
  assign retire   = vld_p[LATENCY-1];
  assign rsp_data = add_result;

  always_comb begin
    rsp_valid = '0;
    if (retire) rsp_valid[id_p[LATENCY-1]] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_flight <= '0;
    end else begin
      case ({add_en, retire})
        2'b10:   in_flight <= in_flight + CNT_W'(1);
        2'b01:   in_flight <= in_flight - CNT_W'(1);
        default: in_flight <= in_flight;
      endcase
    end
  end

  assign idle = (in_flight == '0) && !add_en;

endmodule
